tm1637_ctrl: RTL and testbench

- Memory-mapped hardware serial engine for the TM1637 7-segment display driver.
- Replaces the VIA port-B bit-bang of tm_cs/tm_clk/tm_dio.
- Sits on the 6502 data bus as a slave decoded by the core (one page, 4 registers).
- Drives the TM1637 2-wire pins through an open-drain pad: START, 8 data bits LSB first, ACK check, STOP.

---
 rtl/tm1637_pkg.sv | 53 +++++
 rtl/tm1637_tick.sv | 41 ++++
 rtl/tm1637_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_tm1637_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// ============================================================================
// Module   : tm1637_pkg
// Brief    : Shared constants for the TM1637 serial engine. Holds the register
//            map, the CTRL/STATUS bit positions, the FSM state encoding and
//            the divisor reset default.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tm1637_pkg;

   // Register addresses within the decoded page
   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_DIV    = 2'd3;

   // CTRL bit positions
   localparam int CTRL_AUTO_START = 0;
   localparam int CTRL_AUTO_STOP  = 1;
   localparam int CTRL_IRQ_EN     = 2;

   // STATUS bit positions
   localparam int STAT_BUSY    = 7;
   localparam int STAT_NACK    = 6;
   localparam int STAT_OVERRUN = 5;
   localparam int STAT_DONE    = 4;

   // Half-period divisor at reset: (59+1) clks at 12 MHz gives ~100 kHz
   localparam logic [7:0] DIV_DEFAULT = 8'd59;

   // One state per half-period of tm_clk. BL/BH are reused for all eight
   // data bits with a separate bit index. AW0/AW1 hold the clock low for an
   // extra period before the ACK cell so the data+ACK portion spans 20
   // half-periods.
   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_S0   = 4'd1,
      ST_S1   = 4'd2,
      ST_BL   = 4'd3,
      ST_BH   = 4'd4,
      ST_AW0  = 4'd5,
      ST_AW1  = 4'd6,
      ST_AL   = 4'd7,
      ST_AH   = 4'd8,
      ST_P0   = 4'd9,
      ST_P1   = 4'd10,
      ST_P2   = 4'd11
   } tm_state_t;

endpackage

`default_nettype wire

// File: rtl/tm1637_tick.sv
// ============================================================================
// Module   : tm1637_tick
// Brief    : Loadable down-counter. Emits a one-clk tick every div+1 clks;
//            load restarts the count and latches the divisor for the whole
//            transaction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm1637_tick (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] div,
   output logic       tick
);
   import tm1637_pkg::*;

   logic [7:0] r_div;
   logic [7:0] r_cnt;

   // Count down to zero, then reload from the divisor latched at launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div <= 8'd0;
         r_cnt <= 8'd0;
      end else if (load) begin
         r_div <= div;
         r_cnt <= div;
      end else if (r_cnt == 8'd0) begin
         r_cnt <= r_div;
      end else begin
         r_cnt <= r_cnt - 8'd1;
      end
   end

   assign tick = (r_cnt == 8'd0);

endmodule

`default_nettype wire

// File: rtl/tm1637_ctrl.sv
// ============================================================================
// Module   : tm1637_ctrl
// Brief    : Memory-mapped TM1637 serial engine on the 6502 bus. Sends
//            optional START, 8 data bits LSB first, ACK check, optional STOP
//            through an open-drain DIO pad.
//            Build option: define TM1637_IRQ_EN to add the irq output and the
//            CTRL.IRQ_EN bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tm1637_ctrl #(
   parameter logic [7:0] DIV_DEFAULT = tm1637_pkg::DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       tm_clk,
   output logic       tm_dio_oe,
   input  logic       tm_dio_in,
   output logic       busy
`ifdef TM1637_IRQ_EN
   ,
   output logic       irq
`endif
);
   import tm1637_pkg::*;

`ifdef TM1637_IRQ_EN
   localparam logic [2:0] CTRL_MASK = 3'b111;
`else
   localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

   tm_state_t  r_state, w_state_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic [7:0] r_byte, w_byte_nxt;
   logic       r_parked, w_parked_nxt;
   logic       r_auto_stop;
   logic [2:0] r_ctrl;
   logic [7:0] r_div;
   logic       r_nack, r_overrun, r_done;
   logic       w_nack_set, w_done_set;
   logic       w_tm_clk_nxt, w_dio_oe_nxt;
   logic       w_tick;
   logic [7:0] w_status, w_rdata;

   wire w_wr          = cs & we;
   wire w_launch      = w_wr && (addr == REG_TXDATA) && (r_state == ST_IDLE);
   wire w_overrun_set = w_wr && (addr == REG_TXDATA) && (r_state != ST_IDLE);
   wire w_stat_clr    = w_wr && (addr == REG_STATUS);

   assign busy = (r_state != ST_IDLE);

   tm1637_tick u_tick (
      .clk   (clk),
      .reset (reset),
      .load  (w_launch),
      .div   (r_div),
      .tick  (w_tick)
   );

   // State, shift data and pin registers; pins are registered from the next
   // state so the pad never sees decode glitches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_bit       <= 3'd0;
         r_byte      <= 8'h00;
         r_parked    <= 1'b0;
         r_auto_stop <= 1'b0;
         tm_clk      <= 1'b1;
         tm_dio_oe   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit     <= w_bit_nxt;
         r_byte    <= w_byte_nxt;
         r_parked  <= w_parked_nxt;
         tm_clk    <= w_tm_clk_nxt;
         tm_dio_oe <= w_dio_oe_nxt;
         if (w_launch) begin
            r_auto_stop <= r_ctrl[CTRL_AUTO_STOP];
         end
      end
   end

   // Next-state sequencing (one state per tick) and next pin levels
   always_comb begin
      w_state_nxt  = r_state;
      w_bit_nxt    = r_bit;
      w_byte_nxt   = r_byte;
      w_parked_nxt = r_parked;
      w_nack_set   = 1'b0;
      w_done_set   = 1'b0;
      w_tm_clk_nxt = 1'b1;
      w_dio_oe_nxt = 1'b0;

      unique case (r_state)
         ST_IDLE: if (w_launch) begin
            w_state_nxt  = r_ctrl[CTRL_AUTO_START] ? ST_S0 : ST_BL;
            w_bit_nxt    = 3'd0;
            w_byte_nxt   = data_in;
            w_parked_nxt = 1'b0;
         end
         ST_S0:  if (w_tick) w_state_nxt = ST_S1;
         ST_S1:  if (w_tick) w_state_nxt = ST_BL;
         ST_BL:  if (w_tick) w_state_nxt = ST_BH;
         ST_BH:  if (w_tick) begin
            w_bit_nxt   = r_bit + 3'd1;
            w_state_nxt = (r_bit == 3'd7) ? ST_AW0 : ST_BL;
         end
         ST_AW0: if (w_tick) w_state_nxt = ST_AW1;
         ST_AW1: if (w_tick) w_state_nxt = ST_AL;
         ST_AL:  if (w_tick) w_state_nxt = ST_AH;
         ST_AH:  if (w_tick) begin
            // Last clk of AH: a high DIO means the display did not ACK
            w_nack_set = tm_dio_in;
            if (r_auto_stop) begin
               w_state_nxt = ST_P0;
            end else begin
               w_state_nxt  = ST_IDLE;
               w_parked_nxt = 1'b1;
               w_done_set   = 1'b1;
            end
         end
         ST_P0:  if (w_tick) w_state_nxt = ST_P1;
         ST_P1:  if (w_tick) w_state_nxt = ST_P2;
         ST_P2:  if (w_tick) begin
            w_state_nxt = ST_IDLE;
            w_done_set  = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      unique case (w_state_nxt)
         ST_IDLE: w_tm_clk_nxt = ~w_parked_nxt;
         ST_S1:   w_dio_oe_nxt = 1'b1;
         ST_BL: begin
            w_tm_clk_nxt = 1'b0;
            w_dio_oe_nxt = ~w_byte_nxt[w_bit_nxt];
         end
         ST_BH:   w_dio_oe_nxt = ~w_byte_nxt[w_bit_nxt];
         ST_AW0, ST_AW1, ST_AL: w_tm_clk_nxt = 1'b0;
         ST_P0: begin
            w_tm_clk_nxt = 1'b0;
            w_dio_oe_nxt = 1'b1;
         end
         ST_P1:   w_dio_oe_nxt = 1'b1;
         default: begin
            w_tm_clk_nxt = 1'b1;
            w_dio_oe_nxt = 1'b0;
         end
      endcase
   end

   // CPU-writable registers and sticky status flags (a set beats a clear)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl    <= 3'd0;
         r_div     <= DIV_DEFAULT;
         r_nack    <= 1'b0;
         r_overrun <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         if (w_wr && (addr == REG_CTRL)) r_ctrl <= data_in[2:0] & CTRL_MASK;
         if (w_wr && (addr == REG_DIV))  r_div  <= data_in;
         if (w_nack_set)         r_nack <= 1'b1;
         else if (w_stat_clr)    r_nack <= 1'b0;
         if (w_overrun_set)      r_overrun <= 1'b1;
         else if (w_stat_clr)    r_overrun <= 1'b0;
         if (w_done_set)         r_done <= 1'b1;
         else if (w_stat_clr)    r_done <= 1'b0;
      end
   end

   // Read mux for the registered read port
   always_comb begin
      w_status               = 8'h00;
      w_status[STAT_BUSY]    = busy;
      w_status[STAT_NACK]    = r_nack;
      w_status[STAT_OVERRUN] = r_overrun;
      w_status[STAT_DONE]    = r_done;
      w_rdata                = 8'h00;
      case (addr)
         REG_CTRL:   w_rdata = {5'd0, r_ctrl};
         REG_STATUS: w_rdata = w_status;
         REG_DIV:    w_rdata = r_div;
         default:    w_rdata = 8'h00;
      endcase
   end

   // Read data lags the address by one clk to match the core's read timing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out <= 8'h00;
      else        data_out <= w_rdata;
   end

`ifdef TM1637_IRQ_EN
   assign irq = r_done & r_ctrl[CTRL_IRQ_EN];
`endif

endmodule

`default_nettype wire

// File: tb/tb_tm1637_ctrl.sv
// ============================================================================
// Module   : tb_tm1637_ctrl
// Brief    : Scoreboard bench for tm1637_ctrl. Stimulus pushes expected read
//            data and expected wire frames; independent monitors compare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tm1637_ctrl;

   localparam logic [1:0] A_TX = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_DIV = 2'd3;

   logic       clk, reset, cs, we, tm_clk, tm_dio_oe, tm_dio_in, busy;
   logic [1:0] addr;
   logic [7:0] data_in, data_out;
   logic       dev_level;
   logic       rd_req, rd_req_d;
`ifdef TM1637_IRQ_EN
   logic       irq;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [49:0] trace;
      int          nst;
      int          dv;
      logic        end_clk;
      logic        irq_exp;
   } frame_t;

   frame_t      fq[$];
   logic [7:0]  rq[$];
   string       rn[$];

   // Open-drain line: pulled low by the controller or driven by the display
   assign tm_dio_in = tm_dio_oe ? 1'b0 : dev_level;

   tm1637_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs),
      .we        (we),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .tm_clk    (tm_clk),
      .tm_dio_oe (tm_dio_oe),
      .tm_dio_in (tm_dio_in),
      .busy      (busy)
`ifdef TM1637_IRQ_EN
      ,
      .irq       (irq)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Expected wire frame: {tm_clk, dio_oe} per half-period
   function automatic frame_t mk(input logic [7:0] b, input bit st, input bit sp,
                                 input int dv, input bit ie);
      frame_t f;
      int s;
      f.trace = '0;
      s = 0;
      if (st) begin
         f.trace[2*s +: 2] = 2'b10; s++;
         f.trace[2*s +: 2] = 2'b11; s++;
      end
      for (int i = 0; i < 8; i++) begin
         f.trace[2*s +: 2] = {1'b0, ~b[i]}; s++;
         f.trace[2*s +: 2] = {1'b1, ~b[i]}; s++;
      end
      f.trace[2*s +: 2] = 2'b00; s++;
      f.trace[2*s +: 2] = 2'b00; s++;
      f.trace[2*s +: 2] = 2'b00; s++;
      f.trace[2*s +: 2] = 2'b10; s++;
      if (sp) begin
         f.trace[2*s +: 2] = 2'b01; s++;
         f.trace[2*s +: 2] = 2'b11; s++;
         f.trace[2*s +: 2] = 2'b10; s++;
      end
      f.nst     = s;
      f.dv      = dv;
      f.end_clk = sp;
      f.irq_exp = ie;
      return f;
   endfunction

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
      rq.push_back(exp);
      rn.push_back(nm);
      cs = 1'b1; we = 1'b0; addr = a; rd_req = 1'b1;
      @(negedge clk);
      cs = 1'b0; rd_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL wait_idle: busy=%b after %0d clks, expected 0", busy, n);
      end
      @(negedge clk);
   endtask

   // Read monitor: data_out is valid one clk after a read address
   always @(posedge clk) rd_req_d <= rd_req;

   initial begin : read_mon
      forever begin
         @(negedge clk);
         if (rd_req_d === 1'b1) begin
            if (rq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL read_unexpected: got 0x%0h, expected no read", data_out);
            end else begin
               chk(rn.pop_front(), data_out, rq.pop_front());
            end
         end
      end
   end

   // Frame monitor: captures the pins over one busy window and scores it
   initial begin : frame_mon
      frame_t      e;
      bit          have, unstable, irq_early;
      int          n, s;
      logic [49:0] act;
      logic [1:0]  cur;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            have = (fq.size() > 0);
            if (have) e = fq.pop_front();
            else      e = mk(8'h00, 1'b0, 1'b0, 0, 1'b0);
            n = 0; act = '0; unstable = 1'b0; irq_early = 1'b0;
            while (busy === 1'b1 && n < 8000) begin
               cur = {tm_clk, tm_dio_oe};
               s   = n / (e.dv + 1);
               if (s < 25) begin
                  if (n % (e.dv + 1) == 0)       act[2*s +: 2] = cur;
                  else if (act[2*s +: 2] !== cur) unstable = 1'b1;
               end
`ifdef TM1637_IRQ_EN
               if (irq === 1'b1) irq_early = 1'b1;
`endif
               n++;
               @(negedge clk);
            end
            if (have) begin
               chk("frame_len", n, e.nst * (e.dv + 1));
               chk("frame_pins", act, e.trace);
               chk("frame_stable", unstable, 1'b0);
               chk("idle_tm_clk", tm_clk, e.end_clk);
               chk("idle_dio", tm_dio_oe, 1'b0);
`ifdef TM1637_IRQ_EN
               chk("irq_during_frame", irq_early, 1'b0);
               chk("irq_at_end", irq, e.irq_exp);
`endif
            end
         end
      end
   end

   initial begin : stim
      int n;
      reset = 1'b0; cs = 1'b0; we = 1'b0; addr = 2'd0; data_in = 8'h00;
      rd_req = 1'b0; dev_level = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tm_clk", tm_clk, 1'b1);
      chk("rst_dio", tm_dio_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data_out", data_out, 8'h00);
      reset = 1'b1;
      @(negedge clk);
      rd(A_STAT, 8'h00, "status_reset");
      rd(A_DIV,  8'h3B, "div_reset");
      rd(A_CTRL, 8'h00, "ctrl_reset");

      // Reset in the middle of a default-divisor frame
      wr(A_TX, 8'h55);
      repeat (100) @(negedge clk);
      chk("busy_midframe", busy, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_tm_clk", tm_clk, 1'b1);
      chk("abort_dio", tm_dio_oe, 1'b0);
      chk("abort_busy", busy, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      rd(A_STAT, 8'h00, "status_after_abort");
      rd(A_DIV,  8'h3B, "div_after_abort");

      // START+STOP frame, ACK given
      wr(A_DIV, 8'h00);
      rd(A_DIV, 8'h00, "div_write");
      wr(A_CTRL, 8'h03);
      rd(A_CTRL, 8'h03, "ctrl_write");
      fq.push_back(mk(8'h40, 1'b1, 1'b1, 0, 1'b0));
      wr(A_TX, 8'h40);
      wait_idle();
      rd(A_STAT, 8'h10, "status_ack");
      wr(A_STAT, 8'h00);

      // No ACK from the display
      dev_level = 1'b1;
      fq.push_back(mk(8'h5A, 1'b1, 1'b1, 0, 1'b0));
      wr(A_TX, 8'h5A);
      wait_idle();
      rd(A_STAT, 8'h50, "status_nack");
      wr(A_STAT, 8'h00);
      rd(A_STAT, 8'h00, "status_cleared");

      // Second TXDATA write three clks after launch
      dev_level = 1'b0;
      fq.push_back(mk(8'hA5, 1'b1, 1'b1, 0, 1'b0));
      wr(A_TX, 8'hA5);
      repeat (2) @(negedge clk);
      wr(A_TX, 8'hFF);
      wait_idle();
      rd(A_STAT, 8'h30, "status_overrun");
      wr(A_STAT, 8'h00);

      // Bare frames without START/STOP, the second from the parked state
      wr(A_CTRL, 8'h00);
      fq.push_back(mk(8'h3C, 1'b0, 1'b0, 0, 1'b0));
      wr(A_TX, 8'h3C);
      wait_idle();
      fq.push_back(mk(8'hC0, 1'b0, 1'b0, 0, 1'b0));
      wr(A_TX, 8'hC0);
      wait_idle();
      rd(A_STAT, 8'h10, "status_parked");
      wr(A_STAT, 8'h00);

      // STATUS clear on the same clk as the NACK sample: the set wins
      wr(A_CTRL, 8'h02);
      dev_level = 1'b1;
      fq.push_back(mk(8'h96, 1'b0, 1'b1, 0, 1'b0));
      wr(A_TX, 8'h96);
      repeat (19) @(negedge clk);
      wr(A_STAT, 8'h00);
      wait_idle();
      rd(A_STAT, 8'h50, "status_clear_vs_nack");
      wr(A_STAT, 8'h00);

      // Divisor 4 with interrupt enabled
      dev_level = 1'b0;
      wr(A_DIV, 8'h04);
      rd(A_DIV, 8'h04, "div4_write");
      wr(A_CTRL, 8'h07);
`ifdef TM1637_IRQ_EN
      rd(A_CTRL, 8'h07, "ctrl_irq_write");
      fq.push_back(mk(8'h81, 1'b1, 1'b1, 4, 1'b1));
`else
      rd(A_CTRL, 8'h03, "ctrl_irq_write");
      fq.push_back(mk(8'h81, 1'b1, 1'b1, 4, 1'b0));
`endif
      wr(A_TX, 8'h81);
      rd(A_STAT, 8'h80, "status_busy");
      wait_idle();
`ifdef TM1637_IRQ_EN
      chk("irq_level", irq, 1'b1);
      wr(A_STAT, 8'h00);
      chk("irq_cleared", irq, 1'b0);
`else
      wr(A_STAT, 8'h00);
`endif
      rd(A_STAT, 8'h00, "status_final");

      n = 0;
      while ((fq.size() != 0 || rq.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (fq.size() != 0 || rq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: frames=%0d reads=%0d outstanding, expected 0", fq.size(), rq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
